// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: wrap counter with IDLE/RUN/PAUSE/DONE sequencing and round tracking.
// Define ROUND_LIMIT_EN to end a run after cfg_rounds wraps; otherwise a run only ends on stop.
module counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int RWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_limit,
    input  logic [RWIDTH-1:0] cfg_rounds,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [RWIDTH-1:0] round_cnt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    state_t r_state;
    logic [WIDTH-1:0] r_count, r_limit;
    logic [RWIDTH-1:0] r_round;
    logic w_advance, w_wrap, w_last;
    assign w_advance = r_state == RUN && !stop && !pause;
    assign w_wrap    = r_count == r_limit;
`ifdef ROUND_LIMIT_EN
    logic [RWIDTH-1:0] r_rounds;
    // zero rounds means run forever
    assign w_last = r_rounds != '0 && r_round + 1'b1 == r_rounds;
    assign done   = r_state == DONE;
`else
    logic w_unused_rounds;
    assign w_unused_rounds = ^cfg_rounds;
    assign w_last = 1'b0;
    assign done   = 1'b0;
`endif
    assign cfg_ready = r_state == IDLE;
    assign tc        = w_advance && w_wrap;
    assign busy      = r_state == RUN || r_state == PAUSE;
    assign count     = r_count;
    assign round_cnt = r_round;
    assign state     = r_state;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_round <= '0;
            r_limit <= WIDTH'(13);
`ifdef ROUND_LIMIT_EN
            r_rounds <= RWIDTH'(1);
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        r_limit <= cfg_limit;
`ifdef ROUND_LIMIT_EN
                        r_rounds <= cfg_rounds;
`endif
                    end
                    if (start) begin
                        r_state <= RUN;
                        r_count <= '0;
                        r_round <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (pause) begin
                        r_state <= PAUSE;
                    end else if (w_wrap) begin
                        r_count <= '0;
                        r_round <= r_round + 1'b1;
                        if (w_last) r_state <= DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (!pause) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed checks of counting, wrap, pause/stop, config and reset behaviour.
module tb_counter_seq_ctrl;
    logic       clk = 1'b0, reset = 1'b1, cfg_valid = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic [3:0] cfg_limit = '0;
    logic [7:0] cfg_rounds = '0;
    logic       cfg_ready, tc, busy, done;
    logic [3:0] count;
    logic [7:0] round_cnt;
    logic [1:0] state;
    int checks = 0, failures = 0, tc_pulses = 0;

    counter_seq_ctrl dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_limit(cfg_limit), .cfg_rounds(cfg_rounds), .start(start), .pause(pause),
        .stop(stop), .count(count), .tc(tc), .round_cnt(round_cnt), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_round", round_cnt, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_tc", tc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        // default run; config attempt during RUN is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_state", state, 1);
        chk("run_count0", count, 0);
        chk("run_busy", busy, 1);
        cfg_valid = 1'b1;
        cfg_limit = 4'd2;
        #1;
        chk("run_ready", cfg_ready, 0);
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk("def_count", count, i);
        end
        cfg_valid = 1'b0;
        chk("def_tc13", tc, 1);
        tick();
        chk("def_wrap_count", count, 0);
        chk("def_wrap_round", round_cnt, 1);
`ifdef ROUND_LIMIT_EN
        chk("def_done_state", state, 3);
        chk("def_done", done, 1);
        chk("def_done_busy", busy, 0);
        tick();
        chk("def_after_done", state, 0);
        chk("def_done_clear", done, 0);
`else
        chk("def_keep_run", state, 1);
        chk("def_no_done", done, 0);
        stop = 1'b1;
        #1;
        chk("stop_masks_tc", tc, 0);
        tick();
        stop = 1'b0;
        chk("def_stop_state", state, 0);
`endif
        chk("def_round_held", round_cnt, 1);
        // config and start in the same cycle
        cfg_valid = 1'b1;
        cfg_limit = 4'd3;
        cfg_rounds = 8'd2;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        chk("c3_state", state, 1);
        chk("c3_count0", count, 0);
        chk("c3_round0", round_cnt, 0);
        for (int i = 1; i <= 7; i++) begin
            chk("c3_tc", tc, ((i - 1) % 4 == 3) ? 1 : 0);
            if (tc) tc_pulses++;
            tick();
            chk("c3_count", count, i % 4);
        end
        chk("c3_tc_last", tc, 1);
        if (tc) tc_pulses++;
        tick();
        chk("c3_tc_pulses", tc_pulses, 2);
        chk("c3_round2", round_cnt, 2);
        chk("c3_count_end", count, 0);
`ifdef ROUND_LIMIT_EN
        chk("c3_done", done, 1);
        tick();
`else
        chk("c3_no_done", done, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif
        chk("c3_idle", state, 0);
        // pause hold and stop from PAUSE
        cfg_valid = 1'b1;
        cfg_limit = 4'd13;
        cfg_rounds = 8'd0;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        repeat (5) tick();
        chk("p_count5", count, 5);
        pause = 1'b1;
        #1;
        chk("p_tc_masked", tc, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("p_state", state, 2);
            chk("p_count", count, 5);
        end
        chk("p_busy", busy, 1);
        pause = 1'b0;
        tick();
        chk("p_resume_state", state, 1);
        chk("p_resume_count", count, 5);
        tick();
        chk("p_count6", count, 6);
        tick();
        pause = 1'b1;
        tick();
        chk("p_hold7", count, 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        pause = 1'b0;
        chk("ps_state", state, 0);
        chk("ps_count", count, 0);
        chk("ps_done", done, 0);
        chk("ps_round", round_cnt, 0);
        // limit of zero wraps every advancing cycle
        cfg_valid = 1'b1;
        cfg_limit = 4'd0;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        chk("z_tc", tc, 1);
        tick();
        chk("z_count", count, 0);
        chk("z_round1", round_cnt, 1);
        chk("z_tc2", tc, 1);
        tick();
        chk("z_round2", round_cnt, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        // reset overrides a running count, config and start
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        cfg_valid = 1'b1;
        cfg_limit = 4'd5;
        start = 1'b1;
        tick();
        reset = 1'b0;
        cfg_valid = 1'b0;
        start = 1'b0;
        chk("rr_state", state, 0);
        chk("rr_count", count, 0);
        chk("rr_round", round_cnt, 0);
        chk("rr_ready", cfg_ready, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            if (i == 6) start = 1'b1;
            tick();
            start = 1'b0;
            chk("rr_count_run", count, i);
        end
        chk("rr_tc13", tc, 1);
        tick();
        chk("rr_round1", round_cnt, 1);
`ifdef ROUND_LIMIT_EN
        chk("rr_done", done, 1);
        tick();
`else
        stop = 1'b1;
        tick();
        stop = 1'b0;
        // unlimited rounds: limit 1 toggles and rounds keep climbing
        cfg_valid = 1'b1;
        cfg_limit = 4'd1;
        cfg_rounds = 8'd1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("u_count", count, i % 2);
            chk("u_round", round_cnt, i / 2);
            chk("u_done", done, 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("u_stop_round", round_cnt, 3);
`endif
        chk("end_idle", state, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the count and limit width in bits.
REQ-002 Parameter RWIDTH, default 8, sets the round-counter and round-target width in bits.
REQ-003 Port clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Port cfg_valid  input  1  is the configuration request.
REQ-006 Port cfg_ready  output  1  is high when configuration is accepted.
REQ-007 Port cfg_limit  input  WIDTH  is the terminal count value.
REQ-008 Port cfg_rounds  input  RWIDTH  is the number of wraps before completion; 0 means unlimited.
REQ-009 Port start  input  1  requests a count run.
REQ-010 Port pause  input  1  is a level-sensitive hold request.
REQ-011 Port stop  input  1  aborts the current run.
REQ-012 Port count  output  WIDTH  is the current count value.
REQ-013 Port tc  output  1  is the terminal-count indicator.
REQ-014 Port round_cnt  output  RWIDTH  is the number of completed wraps.
REQ-015 Port busy  output  1  is high while in the RUN or PAUSE state.
REQ-016 Port done  output  1  is a one-cycle run-complete pulse.
REQ-017 Port state  output  2  gives the FSM encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-018 cfg_ready SHALL equal (state==IDLE); when cfg_valid and cfg_ready are both high, limit_q<=cfg_limit and rounds_q<=cfg_rounds.
REQ-019 In IDLE, start SHALL move the FSM to RUN next cycle with count<=0 and round_cnt<=0.
REQ-020 If cfg_valid and start are high in the same IDLE cycle, the run SHALL use the newly latched configuration.
REQ-021 start SHALL be ignored outside IDLE, and cfg_valid SHALL be ignored outside IDLE with no register change.
REQ-022 In RUN, priority SHALL be stop > pause > advance.
REQ-023 On advance, count<=count+1 when count!=limit_q; otherwise count<=0 and round_cnt<=round_cnt+1, wrapping modulo 2^RWIDTH.
REQ-024 tc SHALL equal (state==RUN && count==limit_q && !stop && !pause), i.e., high only in cycles where a wrap occurs.
REQ-025 If limit_q==0, count SHALL stay 0 and tc SHALL be high on every advancing RUN cycle.
REQ-026 pause in RUN SHALL move the FSM to PAUSE; count does not advance in that cycle and is held in PAUSE.
REQ-027 In PAUSE, deasserting pause SHALL move the FSM to RUN, and advance resumes the following cycle.
REQ-028 stop in RUN or PAUSE SHALL move the FSM to IDLE with count<=0 and round_cnt held; done SHALL not assert.
REQ-029 The DONE state SHALL last exactly one cycle with done=1, then return to IDLE; count stays 0 and round_cnt is held.
REQ-030 done SHALL be 0 in every state except DONE.
REQ-031 busy SHALL be 0 in IDLE and DONE.

Reset
REQ-032 reset SHALL set state=IDLE, count=0, round_cnt=0, limit_q=13 and rounds_q=1; all outputs then read cfg_ready=1 and tc=busy=done=0.
REQ-033 reset SHALL override every other input in the same cycle, including during RUN or PAUSE.

Configuration
REQ-034 With ROUND_LIMIT_EN defined, a wrap where round_cnt+1==rounds_q and rounds_q!=0 SHALL move the FSM to DONE instead of RUN.
REQ-035 Without ROUND_LIMIT_EN, cfg_rounds SHALL be ignored, DONE is unreachable, done is tied to 0, and RUN continues until stop.

Verification
REQ-036 Defaults with ROUND_LIMIT_EN, start at edge E0 -> count 0..13 after E0..E13; tc high after E13; done high after E14; IDLE after E15.
REQ-037 cfg_limit=3 and cfg_rounds=2 with start in the same cycle -> count 0,1,2,3,0,1,2,3; tc pulses twice; round_cnt=2; one done pulse.
REQ-038 pause held 3 cycles while count=5 -> count stays 5 and state=2 for 3 cycles, then count goes 5 then 6 after release.
REQ-039 stop during PAUSE at count=7 -> next cycle state=0, count=0, done never asserts.
REQ-040 cfg_valid with cfg_limit=2 during RUN -> cfg_ready=0; the run still wraps at 13.
REQ-041 Without ROUND_LIMIT_EN, cfg_rounds=1 and cfg_limit=1 -> count 0,1,0,1,...; round_cnt increments past 1; done stays 0 until stop.
